// File: rtl/pwm_cfg_if.sv
// pwm_cfg_if: config record, commit events and active PWM parameters between parser, scheduler and channels
interface pwm_cfg_if #(
    parameter int CH_NUM = 8,
    parameter int CNT_W  = 28
);
    logic                    cfg_vld;
    logic [7:0]              cfg_channel;
    logic                    cfg_en;
    logic [CNT_W-1:0]        cfg_period;
    logic [CNT_W-1:0]        cfg_hlevel;
    logic [CH_NUM-1:0]       ch_cycle_end;
    logic                    commit_all;
    logic [CH_NUM-1:0]       ch_en;
    logic [CH_NUM*CNT_W-1:0] ch_period;
    logic [CH_NUM*CNT_W-1:0] ch_hlevel;
    logic [CH_NUM-1:0]       ch_load;
    logic [CH_NUM-1:0]       pending;
    logic                    cfg_err;
    logic [15:0]             ovr_cnt;
    logic [15:0]             err_cnt;

    modport master (
        output cfg_vld, cfg_channel, cfg_en, cfg_period, cfg_hlevel, ch_cycle_end, commit_all,
        input  ch_en, ch_period, ch_hlevel, ch_load, pending, cfg_err, ovr_cnt, err_cnt
    );

    modport slave (
        input  cfg_vld, cfg_channel, cfg_en, cfg_period, cfg_hlevel, ch_cycle_end, commit_all,
        output ch_en, ch_period, ch_hlevel, ch_load, pending, cfg_err, ovr_cnt, err_cnt
    );
endinterface

// File: rtl/pwm_cfg_sched.sv
// pwm_cfg_sched: sanitizes PWM config records into per-channel shadows and commits them at safe points
module pwm_cfg_sched #(
    parameter int CH_NUM    = 8,
    parameter int CNT_W     = 28,
    parameter int SYNC_MODE = 0
) (
    input logic clk,
    input logic rst,
    pwm_cfg_if.slave bus
);
    localparam logic [8:0] CH_LIM = 9'(CH_NUM);

    logic             s0_vld, s0_en, s0_bad, s0_ok, san_en, ovr_inc;
    logic [7:0]       s0_ch;
    logic [CNT_W-1:0] s0_per, s0_hl, san_hl;
    logic [CNT_W-1:0] sh_per [CH_NUM];
    logic [CNT_W-1:0] sh_hl [CH_NUM];
    logic [CNT_W-1:0] act_per [CH_NUM];
    logic [CNT_W-1:0] act_hl [CH_NUM];
    logic [CH_NUM-1:0] sh_en, wr, commit;

    always_comb begin
        wr      = '0;
        commit  = '0;
        s0_bad  = s0_vld && ({1'b0, s0_ch} >= CH_LIM);
        s0_ok   = s0_vld && !s0_bad;
        san_en  = s0_en && (s0_per != '0);
        san_hl  = (s0_per == '0) ? '0 : (s0_hl > s0_per) ? s0_per : s0_hl;
        // a disabled channel has no period in flight, so it may take its config immediately
        for (int i = 0; i < CH_NUM; i++) begin
            wr[i]     = s0_ok && (s0_ch == 8'(i));
            commit[i] = bus.pending[i] && (!bus.ch_en[i] || bus.commit_all ||
                        ((SYNC_MODE == 0) && bus.ch_cycle_end[i]));
        end
        ovr_inc = |(wr & bus.pending & ~commit);
    end

    for (genvar i = 0; i < CH_NUM; i++) begin : g_pack
        assign bus.ch_period[i*CNT_W +: CNT_W] = act_per[i];
        assign bus.ch_hlevel[i*CNT_W +: CNT_W] = act_hl[i];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s0_vld      <= 1'b0;
            s0_ch       <= '0;
            s0_en       <= 1'b0;
            s0_per      <= '0;
            s0_hl       <= '0;
            sh_en       <= '0;
            bus.ch_en   <= '0;
            bus.ch_load <= '0;
            bus.pending <= '0;
            bus.cfg_err <= 1'b0;
            bus.ovr_cnt <= '0;
            bus.err_cnt <= '0;
            for (int i = 0; i < CH_NUM; i++) begin
                sh_per[i]  <= '0;
                sh_hl[i]   <= '0;
                act_per[i] <= '0;
                act_hl[i]  <= '0;
            end
        end else begin
            s0_vld      <= bus.cfg_vld;
            s0_ch       <= bus.cfg_channel;
            s0_en       <= bus.cfg_en;
            s0_per      <= bus.cfg_period;
            s0_hl       <= bus.cfg_hlevel;
            bus.cfg_err <= s0_bad;
            bus.ch_load <= commit;
            bus.pending <= wr | (bus.pending & ~commit);
            if (s0_bad && bus.err_cnt != 16'hFFFF)
                bus.err_cnt <= bus.err_cnt + 16'd1;
            if (ovr_inc && bus.ovr_cnt != 16'hFFFF)
                bus.ovr_cnt <= bus.ovr_cnt + 16'd1;
            // commit reads the pre-write shadow, so a same-edge record stays pending
            for (int i = 0; i < CH_NUM; i++) begin
                if (commit[i]) begin
                    bus.ch_en[i] <= sh_en[i];
                    act_per[i]   <= sh_per[i];
                    act_hl[i]    <= sh_hl[i];
                end
                if (wr[i]) begin
                    sh_en[i]  <= san_en;
                    sh_per[i] <= s0_per;
                    sh_hl[i]  <= san_hl;
                end
            end
        end
    end
endmodule

// File: tb/tb_pwm_cfg_sched.sv
// tb_pwm_cfg_sched: directed checks of per-channel and group-commit config scheduling
module tb_pwm_cfg_sched;
    localparam int CH = 8;
    localparam int CW = 28;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cfg_vld = 1'b0;
    logic [7:0]    cfg_channel = '0;
    logic          cfg_en = 1'b0;
    logic [CW-1:0] cfg_period = '0;
    logic [CW-1:0] cfg_hlevel = '0;
    logic [CH-1:0] cyc = '0;
    logic          call = 1'b0;
    int            n_chk = 0;
    int            n_pass = 0;

    always #5 clk = ~clk;

    pwm_cfg_if #(.CH_NUM(CH), .CNT_W(CW)) a ();
    pwm_cfg_if #(.CH_NUM(CH), .CNT_W(CW)) b ();

    assign a.cfg_vld      = cfg_vld;
    assign a.cfg_channel  = cfg_channel;
    assign a.cfg_en       = cfg_en;
    assign a.cfg_period   = cfg_period;
    assign a.cfg_hlevel   = cfg_hlevel;
    assign a.ch_cycle_end = cyc;
    assign a.commit_all   = call;
    assign b.cfg_vld      = cfg_vld;
    assign b.cfg_channel  = cfg_channel;
    assign b.cfg_en       = cfg_en;
    assign b.cfg_period   = cfg_period;
    assign b.cfg_hlevel   = cfg_hlevel;
    assign b.ch_cycle_end = cyc;
    assign b.commit_all   = call;

    pwm_cfg_sched #(.CH_NUM(CH), .CNT_W(CW), .SYNC_MODE(0)) dut0 (.clk(clk), .rst(rst), .bus(a.slave));
    pwm_cfg_sched #(.CH_NUM(CH), .CNT_W(CW), .SYNC_MODE(1)) dut1 (.clk(clk), .rst(rst), .bus(b.slave));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] ch, input logic en, input logic [CW-1:0] p, input logic [CW-1:0] h);
        cfg_channel = ch;
        cfg_en      = en;
        cfg_period  = p;
        cfg_hlevel  = h;
        cfg_vld     = 1'b1;
        tick;
        cfg_vld     = 1'b0;
    endtask

    initial begin
        tick;
        tick;
        chk("rst_en", 32'(a.ch_en), 0);
        chk("rst_pend", 32'(a.pending), 0);
        chk("rst_per2", a.ch_period[2*CW +: CW], 0);
        chk("rst_ovr", 32'(a.ovr_cnt), 0);
        rst = 1'b0;
        send(2, 1, 1000, 250);
        tick;
        tick;
        chk("first_load", 32'(a.ch_load), 32'h04);
        chk("first_per", a.ch_period[2*CW +: CW], 1000);
        chk("first_hl", a.ch_hlevel[2*CW +: CW], 250);
        chk("first_en", 32'(a.ch_en), 32'h04);
        chk("first_pend", 32'(a.pending), 0);
        tick;
        chk("load_once", 32'(a.ch_load), 0);
        send(2, 1, 500, 100);
        repeat (20) tick;
        chk("wait_pend", 32'(a.pending), 32'h04);
        chk("wait_per", a.ch_period[2*CW +: CW], 1000);
        chk("wait_hl", a.ch_hlevel[2*CW +: CW], 250);
        cyc = 8'h04;
        tick;
        cyc = '0;
        chk("ce_load", 32'(a.ch_load), 32'h04);
        chk("ce_per", a.ch_period[2*CW +: CW], 500);
        chk("ce_hl", a.ch_hlevel[2*CW +: CW], 100);
        chk("ce_pend", 32'(a.pending), 0);
        tick;
        chk("ce_load_off", 32'(a.ch_load), 0);
        send(2, 1, 500, 100);
        send(2, 1, 500, 300);
        tick;
        chk("ovr_cnt", 32'(a.ovr_cnt), 1);
        cyc = 8'h04;
        tick;
        cyc = '0;
        chk("ovr_hl", a.ch_hlevel[2*CW +: CW], 300);
        send(9, 1, 10, 5);
        chk("err_early", 32'(a.cfg_err), 0);
        tick;
        chk("err_pulse", 32'(a.cfg_err), 1);
        chk("err_cnt", 32'(a.err_cnt), 1);
        chk("err_pend", 32'(a.pending), 0);
        tick;
        chk("err_off", 32'(a.cfg_err), 0);
        send(5, 1, 0, 7);
        tick;
        tick;
        chk("p0_load", 32'(a.ch_load), 32'h20);
        chk("p0_en", 32'(a.ch_en[5]), 0);
        chk("p0_hl", a.ch_hlevel[5*CW +: CW], 0);
        send(6, 1, 1000, 2000);
        tick;
        tick;
        chk("clamp_hl", a.ch_hlevel[6*CW +: CW], 1000);
        chk("clamp_en", 32'(a.ch_en[6]), 1);
        send(2, 1, 800, 200);
        tick;
        cfg_period = 900;
        cfg_hlevel = 400;
        cfg_vld    = 1'b1;
        tick;
        cfg_vld    = 1'b0;
        cyc        = 8'h04;
        tick;
        cyc        = '0;
        chk("same_per", a.ch_period[2*CW +: CW], 800);
        chk("same_hl", a.ch_hlevel[2*CW +: CW], 200);
        chk("same_load", 32'(a.ch_load), 32'h04);
        chk("same_pend", 32'(a.pending), 32'h04);
        chk("same_ovr", 32'(a.ovr_cnt), 1);
        rst = 1'b1;
        #1;
        chk("arst_en", 32'(a.ch_en), 0);
        chk("arst_pend", 32'(a.pending), 0);
        chk("arst_load", 32'(a.ch_load), 0);
        chk("arst_per", a.ch_period[2*CW +: CW], 0);
        chk("arst_err", 32'(a.err_cnt), 0);
        tick;
        chk("arst_load2", 32'(a.ch_load), 0);
        rst = 1'b0;
        send(0, 1, 100, 10);
        send(1, 1, 200, 20);
        send(3, 1, 300, 30);
        tick;
        tick;
        chk("sync_en", 32'(b.ch_en), 32'h0B);
        send(0, 1, 400, 40);
        send(1, 1, 500, 50);
        send(3, 1, 600, 60);
        tick;
        tick;
        chk("sync_pend", 32'(b.pending), 32'h0B);
        cyc = '1;
        tick;
        cyc = '0;
        chk("sync_ce_pend", 32'(b.pending), 32'h0B);
        chk("sync_ce_load", 32'(b.ch_load), 0);
        chk("sync_ce_per", b.ch_period[0 +: CW], 100);
        call = 1'b1;
        tick;
        call = 1'b0;
        chk("call_load", 32'(b.ch_load), 32'h0B);
        chk("call_pend", 32'(b.pending), 0);
        chk("call_per0", b.ch_period[0 +: CW], 400);
        chk("call_hl3", b.ch_hlevel[3*CW +: CW], 60);
        tick;
        chk("call_load_off", 32'(b.ch_load), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/pwm_cfg_sched.md
Name: pwm_cfg_sched

Overview:
Per-channel configuration scheduler between the PWM parameter parser and the PWM channel generators. It accepts one configuration record per cfg_vld pulse and cleans it up. The record is held in a per-channel shadow register. The scheduler commits the shadow to the channel's active registers only at a safe point, which gives glitch-free period and duty updates. It also supports a synchronous group-commit mode for phase-aligned multi-channel updates.

Parameters:
CH_NUM, 8, number of PWM channels (1-64)
CNT_W, 28, width of period/high-level counts
SYNC_MODE, 0, 0 = each channel commits on its own cycle end; 1 = enabled channels commit only on commit_all

Ports:
clk  input  1  module clock
rst  input  1  asynchronous reset, active-high
cfg_vld  input  1  one-cycle config strobe
cfg_channel  input  8  target channel index
cfg_en  input  1  requested output enable
cfg_period  input  CNT_W  clocks per PWM period
cfg_hlevel  input  CNT_W  high-time clocks
ch_cycle_end  input  CH_NUM  per-channel pulse, last clock of current PWM period
commit_all  input  1  pulse, force commit of every pending channel
ch_en  output  CH_NUM  active enable per channel
ch_period  output  CH_NUM*CNT_W  active period, channel i at [i*CNT_W +: CNT_W]
ch_hlevel  output  CH_NUM*CNT_W  active high-level, same packing
ch_load  output  CH_NUM  one-cycle pulse when channel i's active regs change
pending  output  CH_NUM  shadow holds uncommitted config
cfg_err  output  1  one-cycle pulse, record dropped
ovr_cnt  output  16  count of records overwriting an uncommitted shadow, saturating
err_cnt  output  16  count of dropped records, saturating

Behaviour:
- Reset (async assert, released synchronously to clk):
  - all outputs, shadows, pending and counters go to 0.
  - Reset mid-operation discards all pending records; no ch_load pulse is emitted.
- Stage 0 (edge N, cfg_vld=1): register the record, then sanitize it.
  - cfg_channel >= CH_NUM: drop the record; cfg_err pulses at N+1; err_cnt increments.
  - cfg_period == 0: force en=0 and hlevel=0.
  - cfg_hlevel > cfg_period: clamp hlevel to cfg_period.
- Stage 1 (edge N+1): write the sanitized record to shadow[i] and set pending[i].
  - If pending[i] was already 1 and is not being cleared at this same edge, ovr_cnt increments. The latest record wins.
- Commit condition for channel i, evaluated each edge with pending[i]=1 (registered):
  - a) ch_en[i]==0: commit at the first edge where pending[i]=1, i.e. edge N+2. A disabled channel starts without waiting.
  - b) ch_en[i]==1, SYNC_MODE=0: commit at an edge where ch_cycle_end[i]=1.
  - c) ch_en[i]==1, SYNC_MODE=1: commit at an edge where commit_all=1. ch_cycle_end is ignored.
  - d) commit_all=1 commits every pending channel regardless of mode or ch_en.
- Commit action (single edge):
  - active regs of channel i take the shadow value;
  - pending[i] clears;
  - ch_load[i] is high for exactly the following cycle.
- Simultaneous events:
  - Stage-1 write and commit of the same channel at the same edge: the commit uses the old shadow; the new record is written and pending[i] stays 1. This takes effect at the next commit opportunity.
  - cfg_vld back-to-back every cycle is accepted with no stall and no drop.
- Disabling (en=0 record) follows the same commit rules, so an enabled channel finishes its current period before stopping.
- Active registers never change except on a commit. ch_period and ch_hlevel always satisfy hlevel <= period.
- Counters saturate at 0xFFFF and never wrap.
- Latency, disabled channel: cfg_vld at edge N gives ch_load high after edge N+2, so ch_en is updated 2 cycles after the strobe.

Test Plan:
- Reset, then cfg ch=2, en=1, period=1000, hlevel=250 -> ch_load[2] high after edge N+2; ch_period[2]=1000, ch_hlevel[2]=250, ch_en[2]=1; pending=0.
- Ch 2 enabled, new cfg period=500, hlevel=100; no cycle_end for 20 clks -> pending[2]=1 and outputs still 1000/250. Pulse ch_cycle_end[2] -> 500/100 on the next cycle, ch_load[2] pulses once.
- Two records to ch 2 before any cycle_end (hlevel 100 then 300) -> ovr_cnt=1; the commit applies hlevel=300.
- cfg ch=9 with CH_NUM=8 -> cfg_err pulses at N+1, err_cnt=1, no pending bit set. cfg period=0, en=1 -> commits en=0, hlevel=0. cfg hlevel=2000, period=1000 -> commits hlevel=1000.
- SYNC_MODE=1, ch 0/1/3 enabled; update all three, then toggle ch_cycle_end -> no commit. commit_all pulse -> ch_load=0b1011 in the same cycle, all pending clear.
- Record written at the same edge as cycle_end on a pending channel -> the old shadow commits and pending stays 1. Then assert rst mid-pending -> all outputs return to 0 immediately, no ch_load.
